// File: rtl/sumador_pkg.sv
// Shared definitions for the adder self-test: default width, FSM encoding and sweep length.
package sumador_pkg;

    localparam int DEF_WIDTH = 4;

    // Number of (a, b) pairs in one sweep for a given operand width.
    function automatic int unsigned sweep_len(input int unsigned width);
        return 32'd1 << (2 * width);
    endfunction

    localparam int unsigned SWEEP_LEN = sweep_len(DEF_WIDTH);

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_SWEEP   = 3'd1;
    localparam state_t S_DRAIN   = 3'd2;
    localparam state_t S_CLEAR   = 3'd3;
    localparam state_t S_CHK_CLR = 3'd4;
    localparam state_t S_DONE    = 3'd5;

endpackage

// File: rtl/probador_sumador_chk.sv
// Result checker: one-deep expect pipeline, comparator, saturating error count, first-fail capture.
module probador_sumador_chk
#(
    parameter int WIDTH = sumador_pkg::DEF_WIDTH,
    parameter int ERR_W = 2 * WIDTH + 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_capture,
    input  logic             i_chk_clr,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic             o_mismatch,
    output logic [ERR_W-1:0] o_err_count,
    output logic [WIDTH-1:0] o_fail_a,
    output logic [WIDTH-1:0] o_fail_b
);

    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_exp_a;
    logic [WIDTH-1:0] r_exp_b;
    logic             r_exp_v;
    logic [ERR_W-1:0] r_err;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;

    logic             w_exp_hit;
    logic             w_clr_hit;
    logic [WIDTH-1:0] w_pair_a;
    logic [WIDTH-1:0] w_pair_b;

    // The clear check has no expect entry, so its failing pair is the live operand pair.
    assign w_exp_hit  = r_exp_v && (i_c != r_exp);
    assign w_clr_hit  = i_chk_clr && (i_c != '0);
    assign o_mismatch = w_exp_hit || w_clr_hit;
    assign w_pair_a   = w_exp_hit ? r_exp_a : i_a;
    assign w_pair_b   = w_exp_hit ? r_exp_b : i_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exp    <= '0;
            r_exp_a  <= '0;
            r_exp_b  <= '0;
            r_exp_v  <= 1'b0;
            r_err    <= '0;
            r_fail_a <= '0;
            r_fail_b <= '0;
        end else begin
            r_exp_v <= i_capture;
            if (i_capture) begin
                r_exp   <= i_a + i_b;
                r_exp_a <= i_a;
                r_exp_b <= i_b;
            end
            // A zero count marks the first mismatch of the run; saturation keeps it from wrapping back.
            if (i_clear) begin
                r_err    <= '0;
                r_fail_a <= '0;
                r_fail_b <= '0;
            end else if (o_mismatch) begin
                if (r_err != '1) begin
                    r_err <= r_err + 1'b1;
                end
                if (r_err == '0) begin
                    r_fail_a <= w_pair_a;
                    r_fail_b <= w_pair_b;
                end
            end
        end
    end

    assign o_err_count = r_err;
    assign o_fail_a    = r_fail_a;
    assign o_fail_b    = r_fail_b;

endmodule

// File: rtl/probador_sumador.sv
// On-chip self-test partner for the registered adder: sweeps all operand pairs, then checks the clear.
module probador_sumador
#(
    parameter int WIDTH = sumador_pkg::DEF_WIDTH,
    parameter int ERR_W = 2 * WIDTH + 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] c,
    output logic             enb_o,
    output logic             clr_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    import sumador_pkg::*;

    localparam int unsigned            RUN_PAIRS = sweep_len(WIDTH);
    localparam logic [2*WIDTH-1:0]     LAST_PAIR = (2*WIDTH)'(RUN_PAIRS - 1);

    state_t           r_state;
    logic             r_enb;
    logic             r_clr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_accept;
    logic             w_mismatch;

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_enb   <= 1'b0;
            r_clr   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_SWEEP;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_enb   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                // {a,b} doubles as the sweep counter; the last pair is held so DONE shows it.
                S_SWEEP: begin
                    if ({r_a, r_b} == LAST_PAIR) begin
                        r_state <= S_DRAIN;
                        r_enb   <= 1'b0;
                    end else begin
                        r_b <= r_b + 1'b1;
                        if (r_b == '1) begin
                            r_a <= r_a + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_CLEAR;
                    r_clr   <= 1'b1;
                end
                S_CLEAR: begin
                    r_state <= S_CHK_CLR;
                    r_clr   <= 1'b0;
                end
                // The clear check resolves on this same edge, so fold it into the pass verdict.
                S_CHK_CLR: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (err_count == '0) && !w_mismatch;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_enb   <= 1'b0;
                    r_clr   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    probador_sumador_chk #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_accept),
        .i_capture   (r_state == S_SWEEP),
        .i_chk_clr   (r_state == S_CHK_CLR),
        .i_a         (r_a),
        .i_b         (r_b),
        .i_c         (c),
        .o_mismatch  (w_mismatch),
        .o_err_count (err_count),
        .o_fail_a    (fail_a),
        .o_fail_b    (fail_b)
    );

    assign enb_o = r_enb;
    assign clr_o = r_clr;
    assign a_o   = r_a;
    assign b_o   = r_b;
    assign busy  = r_busy;
    assign done  = r_done;
    assign pass  = r_pass;

endmodule

// File: tb/tb_probador_sumador.sv
// Directed bench: drives probador_sumador against a behavioural adder with selectable faults.
module tb_probador_sumador;

    import sumador_pkg::*;

    localparam int W     = 4;
    localparam int ERR_W = 2 * W + 1;
    localparam int RUN   = SWEEP_LEN + 3;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     c     = '0;
    logic             enb_o;
    logic             clr_o;
    logic [W-1:0]     a_o;
    logic [W-1:0]     b_o;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [W-1:0]     fail_a;
    logic [W-1:0]     fail_b;

    int faultMode  = 0;
    int nCompared  = 0;
    int nMismatch  = 0;
    int runCycles  = 0;

    always #5 clk = ~clk;

    probador_sumador #(
        .WIDTH (W),
        .ERR_W (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .c         (c),
        .enb_o     (enb_o),
        .clr_o     (clr_o),
        .a_o       (a_o),
        .b_o       (b_o),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_a    (fail_a),
        .fail_b    (fail_b)
    );

    // Adder under test: 0 good, 1 c[0] stuck low, 2 ignores clear, 3 sum off by +1.
    always @(posedge clk) begin : adderModel
        logic [W-1:0] sum;
        sum = W'(a_o + b_o + ((faultMode == 3) ? 1 : 0));
        if (faultMode == 1) sum[0] = 1'b0;
        if (enb_o) c <= sum;
        else if (clr_o && faultMode != 2) c <= '0;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Pulses start, optionally pulses it again mid-sweep, and waits for done with a cycle bound.
    task automatic applyStimulus(input int restartAt, output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        checkOutput("busy_after_start", int'(busy), 1);
        while (!done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            start = (cycles == restartAt);
        end
        start = 1'b0;
        checkOutput("done_reached", int'(done), 1);
        checkOutput("busy_in_done", int'(busy), 0);
    endtask

    task automatic checkResults(input string tag, input int expPass, input int expErr,
                                input int expA, input int expB);
        checkOutput({tag, "_pass"},   int'(pass),      expPass);
        checkOutput({tag, "_err"},    int'(err_count), expErr);
        checkOutput({tag, "_fail_a"}, int'(fail_a),    expA);
        checkOutput({tag, "_fail_b"}, int'(fail_b),    expB);
    endtask

    initial begin
        int n;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_busy",  int'(busy),      0);
        checkOutput("rst_done",  int'(done),      0);
        checkOutput("rst_pass",  int'(pass),      0);
        checkOutput("rst_err",   int'(err_count), 0);
        checkOutput("rst_enb",   int'(enb_o),     0);
        checkOutput("rst_clr",   int'(clr_o),     0);
        checkOutput("rst_ab",    int'({a_o, b_o}), 0);
        rst = 1'b1;

        // Good adder.
        faultMode = 0;
        applyStimulus(-1, runCycles);
        checkOutput("good_run_len", runCycles, RUN);
        checkResults("good", 1, 0, 0, 0);
        checkOutput("good_hold_ab", int'({a_o, b_o}), 8'hFF);
        checkOutput("good_hold_enb", int'(enb_o), 0);

        // c[0] stuck at 0: every odd sum fails, first at (0,1).
        faultMode = 1;
        applyStimulus(-1, runCycles);
        checkOutput("stuck_run_len", runCycles, RUN);
        checkResults("stuck", 0, 128, 0, 1);

        // Adder ignores clear: only the clear check fails, reported at (15,15).
        faultMode = 2;
        applyStimulus(-1, runCycles);
        checkResults("noclr", 0, 1, 15, 15);

        // Second start mid-sweep must be ignored.
        faultMode = 0;
        applyStimulus(50, runCycles);
        checkOutput("restart_run_len", runCycles, RUN);
        checkResults("restart", 1, 0, 0, 0);

        // Async reset at pair (7,3), then a fresh clean run.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(a_o == 4'd7 && b_o == 4'd3) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_7_3", int'({a_o, b_o}), 8'h73);
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_enb",  int'(enb_o), 0);
        checkOutput("abort_ab",   int'({a_o, b_o}), 0);
        checkOutput("abort_err",  int'(err_count), 0);
        checkOutput("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(-1, runCycles);
        checkOutput("fresh_run_len", runCycles, RUN);
        checkResults("fresh", 1, 0, 0, 0);

        // +1 offset: every pair fails, clear check passes.
        faultMode = 3;
        applyStimulus(-1, runCycles);
        checkOutput("offset_run_len", runCycles, RUN);
        checkResults("offset", 0, 256, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
